// File: rtl/mag_req_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mag_req_scheduler: round-robin shared iterative floor(sqrt(x^2+y^2)) engine |
// | Optional: MAG_FASTZERO_EN short-circuits requests with a zero operand.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module mag_req_scheduler #(
  parameter int NREQ = 2,
  parameter int W    = 8,
  parameter int IDW  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_x,
  input  logic [NREQ*W-1:0] req_y,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [W:0]        rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic              busy
);

  localparam int c_rw = W + 6;
  localparam int c_cw = $clog2(W + 2);
  localparam logic [c_cw-1:0] c_sq_last   = c_cw'(W - 1);
  localparam logic [c_cw-1:0] c_root_last = c_cw'(W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SQX  = 3'd1,
    S_SQY  = 3'd2,
    S_ROOT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDW-1:0]    r_ptr;
  logic [IDW-1:0]    r_id;
  logic [W:0]        r_data;
  logic [W-1:0]      r_y;
  logic [2*W-1:0]    r_sh;
  logic [W-1:0]      r_mul;
  logic [2*W+1:0]    r_acc;
  logic [c_rw-1:0]   r_rem;
  logic [W:0]        r_q;
  logic [c_cw-1:0]   r_cnt;
`ifdef MAG_FASTZERO_EN
  logic              r_fast;
`endif

  logic [NREQ-1:0]   w_gnt;
  logic [IDW-1:0]    w_gnt_id;
  logic [IDW-1:0]    w_ptr_nxt;
  logic [W-1:0]      w_sel_x;
  logic [W-1:0]      w_sel_y;
  logic              w_accept;
  logic [2*W+1:0]    w_acc_add;
  logic [1:0]        w_two;
  logic [c_rw-1:0]   w_rem_sh;
  logic [c_rw-1:0]   w_qterm;
  logic [c_rw-1:0]   w_rem_nxt;
  logic [W:0]        w_q_nxt;

  // First valid requester at or after the round-robin pointer.
  always_comb begin : arb
    logic found;
    found = 1'b0;
    w_gnt = '0;
    for (int off = 0; off < NREQ; off++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req_valid[i] && (((int'(r_ptr) + off) % NREQ) == i)) begin
          w_gnt[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign req_ready = (rst_n && (r_state == S_IDLE)) ? w_gnt : '0;
  assign w_accept  = |req_ready;

  always_comb begin
    w_gnt_id  = '0;
    w_ptr_nxt = '0;
    w_sel_x   = '0;
    w_sel_y   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_gnt_id  = IDW'(i);
        w_ptr_nxt = (i == NREQ - 1) ? '0 : IDW'(i + 1);
        w_sel_x   = req_x[i*W +: W];
        w_sel_y   = req_y[i*W +: W];
      end
    end
  end

  // Shift-add squaring step and one non-restoring root step.
  assign w_acc_add = r_acc + (r_mul[0] ? {2'b00, r_sh} : '0);
  assign w_two     = r_acc[2*W+1 -: 2];
  assign w_rem_sh  = (r_rem << 2) | {{(c_rw-2){1'b0}}, w_two};
  assign w_qterm   = {{(c_rw-W-3){1'b0}}, r_q, r_rem[c_rw-1], 1'b1};
  assign w_rem_nxt = r_rem[c_rw-1] ? (w_rem_sh + w_qterm) : (w_rem_sh - w_qterm);
  assign w_q_nxt   = {r_q[W-1:0], ~w_rem_nxt[c_rw-1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_SQX;
      S_SQX: begin
`ifdef MAG_FASTZERO_EN
        if (r_fast) w_state_nxt = S_DONE;
        else
`endif
        if (r_cnt == c_sq_last) w_state_nxt = S_SQY;
      end
      S_SQY:  if (r_cnt == c_sq_last)   w_state_nxt = S_ROOT;
      S_ROOT: if (r_cnt == c_root_last) w_state_nxt = S_DONE;
      S_DONE: if (rsp_ready)            w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_data <= '0;
      r_y    <= '0;
      r_sh   <= '0;
      r_mul  <= '0;
      r_acc  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
`ifdef MAG_FASTZERO_EN
      r_fast <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id  <= w_gnt_id;
            r_ptr <= w_ptr_nxt;
            r_y   <= w_sel_y;
            r_sh  <= {{W{1'b0}}, w_sel_x};
            r_mul <= w_sel_x;
            r_acc <= '0;
            r_cnt <= '0;
`ifdef MAG_FASTZERO_EN
            r_fast <= (w_sel_x == '0) || (w_sel_y == '0);
            if ((w_sel_x == '0) || (w_sel_y == '0))
              r_data <= {1'b0, w_sel_x | w_sel_y};
`endif
          end
        end
        S_SQX, S_SQY: begin
          r_acc <= w_acc_add;
          if (r_cnt == c_sq_last) begin
            // Reload the multiplier with y; the root state starts clean.
            r_cnt <= '0;
            r_sh  <= {{W{1'b0}}, r_y};
            r_mul <= r_y;
            r_rem <= '0;
            r_q   <= '0;
          end else begin
            r_cnt <= r_cnt + c_cw'(1);
            r_sh  <= r_sh << 1;
            r_mul <= r_mul >> 1;
          end
        end
        S_ROOT: begin
          r_acc <= r_acc << 2;
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt + c_cw'(1);
          if (r_cnt == c_root_last) r_data <= w_q_nxt;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == S_DONE);
  assign rsp_data  = r_data;
  assign rsp_id    = r_id;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mag_req_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mag_req_scheduler: directed + randomized checks against a magnitude model |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_mag_req_scheduler;
  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [W:0]        rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int dbl    = 0;
  int mdl_ptr;

  always #5 clk = ~clk;

  mag_req_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  always @(negedge clk) if ($countones(req_ready) > 1) dbl++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_mag(input int x, input int y);
    int s;
    int r;
    s = x * x + y * y;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic int exp_lat(input int x, input int y);
`ifdef MAG_FASTZERO_EN
    if (x == 0 || y == 0) return 1;
`endif
    return 3 * W + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One job on requester r; hold > 0 keeps rsp_ready low that many cycles.
  task automatic do_job(input int r, input int x, input int y, input int hold);
    int n;
    int lat;
    req_x[r*W +: W] = W'(x);
    req_y[r*W +: W] = W'(y);
    req_valid[r]    = 1'b1;
    rsp_ready       = (hold == 0);
    #1;
    n = 0;
    while (req_ready !== NREQ'(1 << r) && n < 50) begin tick(); n++; end
    chk("grant", req_ready, 1 << r);
    tick();
    mdl_ptr   = (r + 1) % NREQ;
    req_valid = '0;
    req_x     = NREQ*W'($urandom);
    req_y     = NREQ*W'($urandom);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
    chk("latency", lat, exp_lat(x, y));
    chk("data", rsp_data, ref_mag(x, y));
    chk("id", rsp_id, r);
    chk("busy_done", busy, 1);
    if (hold > 0) begin
      req_valid = '1;
      #1;
      chk("hold_ready0", req_ready, 0);
      for (int h = 0; h < hold; h++) begin
        tick();
        chk("hold_valid", rsp_valid, 1);
        chk("hold_data", rsp_data, ref_mag(x, y));
        chk("hold_id", rsp_id, r);
        chk("hold_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      tick();
      chk("ready_after_hs", req_ready, 1 << mdl_ptr);
      req_valid = '0;
    end else begin
      tick();
    end
    chk("valid_drop", rsp_valid, 0);
    chk("busy_idle", busy, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ox[NREQ];
    int oy[NREQ];
    int n;
    int g;
    int stale;
    int lat;

    rst_n     = 1'b0;
    req_valid = '1;
    req_x     = '0;
    req_y     = '0;
    rsp_ready = 1'b0;
    mdl_ptr   = 0;
    repeat (3) tick();
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    do_job(0, 3, 4, 0);
    do_job(1, 255, 255, 0);
    do_job(1, 255, 0, 0);
    do_job(0, 1, 1, 0);
    do_job(0, 0, 0, 0);
    do_job(0, 0, 7, 0);

    // Both requesters valid throughout: grants alternate.
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      ox[i] = $urandom_range(0, 255);
      oy[i] = $urandom_range(0, 255);
      req_x[i*W +: W] = W'(ox[i]);
      req_y[i*W +: W] = W'(oy[i]);
    end
    req_valid = '1;
    for (int j = 0; j < 4; j++) begin
      #1;
      n = 0;
      while (req_ready == '0 && n < 100) begin tick(); n++; end
      chk("rr_grant", req_ready, 1 << mdl_ptr);
      g = mdl_ptr;
      tick();
      mdl_ptr = (g + 1) % NREQ;
      lat = 0;
      while (rsp_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
      chk("rr_data", rsp_data, ref_mag(ox[g], oy[g]));
      chk("rr_id", rsp_id, g);
      ox[g] = $urandom_range(0, 255);
      oy[g] = $urandom_range(0, 255);
      req_x[g*W +: W] = W'(ox[g]);
      req_y[g*W +: W] = W'(oy[g]);
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();

    do_job(1, 100, 27, 10);

    for (int k = 0; k < 8; k++) begin
      int rx;
      int ry;
      rx = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
      ry = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(0, 255));
      do_job(int'($urandom_range(0, NREQ - 1)), rx, ry, int'($urandom_range(0, 3)));
    end

    // Abort mid-root with a reset; nothing may come out afterwards.
    req_x[1*W +: W] = W'(200);
    req_y[1*W +: W] = W'(150);
    req_valid[1]    = 1'b1;
    #1;
    n = 0;
    while (req_ready !== 2'b10 && n < 50) begin tick(); n++; end
    chk("abort_grant", req_ready, 2);
    tick();
    req_valid = '0;
    repeat (2 * W + 3) tick();
    chk("abort_busy", busy, 1);
    req_valid = '1;
    rst_n     = 1'b0;
    #1;
    chk("abort_valid", rsp_valid, 0);
    chk("abort_data", rsp_data, 0);
    chk("abort_id", rsp_id, 0);
    chk("abort_busyrst", busy, 0);
    chk("abort_ready", req_ready, 0);
    tick();
    chk("abort_ready2", req_ready, 0);
    req_valid = '0;
    rst_n     = 1'b1;
    mdl_ptr   = 0;
    stale = 0;
    repeat (40) begin
      tick();
      if (rsp_valid !== 1'b0) stale++;
    end
    chk("no_stale", stale, 0);
    do_job(0, 6, 8, 0);

    chk("onehot_ready", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
